rgmii_rx_deframer: RTL and testbench
====================================

// Module: rgmii_rx_deframer
// PURPOSE
//   Receive-side companion of the nibble-serial RGMII transmit stage. One RGMII nibble is sampled per clk.
//   The block strips the preamble and SFD, pairs nibbles into bytes (low nibble first) and checks FCS, length and alignment.
//   It delivers a byte stream with sof/eof/err markers to the MAC RX logic and keeps good/bad frame counters.
// PARAMETERS
//   MIN_FRAME  64    minimum legal length in bytes, DA..FCS inclusive
//   MAX_FRAME  1518  maximum legal length in bytes, DA..FCS inclusive
// PORTS
//   clk        in   1   clock; one RGMII nibble per rising edge
//   rst        in   1   synchronous, active-high reset
//   rx_ctrl    in   1   RGMII RX_CTL (data valid), sampled each clk
//   rxd        in   4   RGMII RXD nibble
//   out_data   out  8   received byte
//   out_valid  out  1   out_data valid this cycle
//   out_sof    out  1   first byte after SFD; qualified by out_valid
//   out_eof    out  1   last byte of frame; qualified by out_valid
//   out_err    out  1   frame bad (CRC, length, dribble); meaningful only with out_eof
//   out_len    out  11  frame byte count including FCS; meaningful only with out_eof
//   good_cnt   out  16  frames ended without error; saturates at 16'hFFFF
//   bad_cnt    out  16  frames ended with error or with zero bytes; saturates at 16'hFFFF
// BEHAVIOUR
//   Reset: state IDLE. All outputs 0, both counters 0, CRC register = 32'hFFFFFFFF, held byte cleared.
//     Reset mid-frame: outputs drop to 0 the next cycle. No eof is emitted and no counter changes.
//   State IDLE: move to PRE only on a rising rx_ctrl (prev=0, now=1) with rxd==4'h5.
//     rx_ctrl=1 without that condition -> DROP.
//   State PRE: rxd==5 -> stay; rxd==4'hD -> DATA with phase=0; any other nibble -> DROP.
//     rx_ctrl=0 -> IDLE with no output and no count.
//   State DATA: phase 0 latches the low nibble; phase 1 forms byte = {rxd, low}, then feeds crc32_d8.
//     The CRC is reflected, poly 32'hEDB88320, init FFFFFFFF.
//     Each completed byte goes into a one-byte hold register.
//     The previous held byte is emitted (out_valid=1) in the cycle after the phase-1 sample.
//     out_valid is therefore never high on two consecutive cycles.
//   End of frame: the first sample with rx_ctrl=0 while in DATA. The held byte is emitted next cycle with out_eof=1.
//     out_err=1 if any of the following hold:
//       CRC register after the last byte != 32'hDEBB20E3;
//       len < MIN_FRAME;
//       phase==1 at the fall (dribble nibble; the partial nibble is discarded).
//     good_cnt or bad_cnt increments in the same cycle as eof. Then state -> IDLE.
//   Zero-byte frame (SFD immediately followed by rx_ctrl=0): no output; bad_cnt++; state -> IDLE.
//   Oversize: when byte MAX_FRAME+1 completes, the held byte (byte MAX_FRAME) is emitted with eof=1, err=1 and len=MAX_FRAME.
//     bad_cnt++, then state -> DROP.
//   State DROP: no output; rx_ctrl=0 -> IDLE.
//   out_sof=1 only on the first emitted byte of a frame. A 1-byte frame has sof=eof=1 on the same cycle.
//   Latency: last FCS byte -> eof at most 2 clk after the rx_ctrl falling sample.
//   The byte counter is 11 bits and saturates at MAX_FRAME+1; it never wraps.
// STRUCTURE
//   eth_pkg:
//     constants PREAMBLE_NIB=4'h5, SFD_NIB=4'hD, CRC_POLY=32'hEDB88320,
//       CRC_INIT=32'hFFFFFFFF, CRC_RESIDUE=32'hDEBB20E3;
//     state encoding IDLE/PRE/DATA/DROP.
//     These are shared with the TX path and the frame generator.
//   Sub-module crc32_d8: combinational next = f(crc, byte), reflected, LSB first.
//     The deframer instantiates it and holds the CRC register itself.
// TESTING
//   1: 7x55+D5 then 60-byte payload + correct FCS (64 B) -> 64 out_valid pulses, sof on byte 1,
//      eof on byte 64, err=0, len=64, good_cnt=1.
//   2: same frame with bit 0 of byte 20 flipped -> eof on byte 64 with err=1, bad_cnt=1, good_cnt unchanged.
//   3: good frame plus one extra nibble before rx_ctrl falls -> 64 bytes, eof err=1 (dribble), bad_cnt=1.
//   4: preamble 5,5,3,... with rx_ctrl held for 100 nibbles -> no out_valid, counters unchanged;
//      a following good frame -> good_cnt=1.
//   5: runt of 40 B with valid FCS -> eof err=1, len=40.
//      1600-B stream -> eof at byte 1518 with err=1, len=1518, no further output until rx_ctrl low.
//   6: rst for 1 clk at byte 20 with rx_ctrl still high -> outputs 0 next cycle, no eof,
//      ignored until rx_ctrl low; next good frame -> good_cnt=1, bad_cnt=0.

Source files
------------

// File: rtl/eth_pkg.sv
// Ethernet framing constants, deframer state encoding and the reflected CRC-32
// byte step, shared by the RGMII TX/RX paths and the frame generator.
package eth_pkg;

  localparam logic [3:0]  PREAMBLE_NIB = 4'h5;
  localparam logic [3:0]  SFD_NIB      = 4'hD;
  localparam logic [31:0] CRC_POLY     = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE  = 32'hDEBB20E3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PRE  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  // One byte through the reflected CRC-32, LSB of the byte first.
  function automatic logic [31:0] crc32_next8(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) begin
        c = {1'b0, c[31:1]} ^ CRC_POLY;
      end else begin
        c = {1'b0, c[31:1]};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational CRC-32 byte step (reflected, LSB first); the caller owns the
// CRC register.
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [31:0] crc_out
);

  always_comb begin
    crc_out = crc32_next8(crc_in, data_in);
  end

endmodule

// File: rtl/rgmii_rx_deframer.sv
// RGMII receive deframer: strips preamble/SFD, pairs nibbles into bytes, checks
// FCS/length/alignment and emits a marked byte stream plus good/bad counters.
module rgmii_rx_deframer
  import eth_pkg::*;
#(
  parameter int unsigned MIN_FRAME = 32'd64,
  parameter int unsigned MAX_FRAME = 32'd1518
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_ctrl,
  input  logic [3:0]  rxd,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_sof,
  output logic        out_eof,
  output logic        out_err,
  output logic [10:0] out_len,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
);

  localparam logic [10:0] MIN_LEN    = 11'(MIN_FRAME);
  localparam logic [10:0] MAX_LEN    = 11'(MAX_FRAME);
  localparam logic [10:0] MAX_LEN_P1 = 11'(MAX_FRAME + 32'd1);

  logic [1:0]  state_q, state_d;
  logic        prev_ctrl_q, prev_ctrl_d;
  logic        phase_q, phase_d;
  logic [3:0]  low_q, low_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_vld_q, hold_vld_d;
  logic        first_q, first_d;
  logic [31:0] crc_q, crc_d;
  logic [10:0] len_q, len_d;
  logic        eof_pend_q, eof_pend_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        out_sof_q, out_sof_d;
  logic        out_eof_q, out_eof_d;
  logic        out_err_q, out_err_d;
  logic [10:0] out_len_q, out_len_d;
  logic [15:0] good_cnt_q, good_cnt_d;
  logic [15:0] bad_cnt_q, bad_cnt_d;

  logic [7:0]  byte_s;
  logic [31:0] crc_byte_s;
  logic        frame_err_s;
  logic        eof_now_s;
  logic        good_inc_s;
  logic        bad_inc_s;

  assign byte_s      = {rxd, low_q};
  assign frame_err_s = (crc_q != CRC_RESIDUE) || (len_q < MIN_LEN) || phase_q;

  crc32_d8 u_crc (
    .crc_in  (crc_q),
    .data_in (byte_s),
    .crc_out (crc_byte_s)
  );

  // Frame FSM, nibble pairing, hold register and output staging.
  always_comb begin
    state_d     = state_q;
    prev_ctrl_d = rx_ctrl;
    phase_d     = phase_q;
    low_d       = low_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    first_d     = first_q;
    crc_d       = crc_q;
    len_d       = len_q;
    eof_pend_d  = 1'b0;
    out_data_d  = 8'h00;
    out_valid_d = 1'b0;
    out_sof_d   = 1'b0;
    out_eof_d   = 1'b0;
    out_err_d   = 1'b0;
    out_len_d   = 11'd0;
    eof_now_s   = 1'b0;
    good_inc_s  = 1'b0;
    bad_inc_s   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_ctrl && !prev_ctrl_q && (rxd == PREAMBLE_NIB)) begin
          state_d = ST_PRE;
        end else if (rx_ctrl) begin
          state_d = ST_DROP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRE: begin
        if (!rx_ctrl) begin
          state_d = ST_IDLE;
        end else if (rxd == PREAMBLE_NIB) begin
          state_d = ST_PRE;
        end else if (rxd == SFD_NIB) begin
          state_d    = ST_DATA;
          phase_d    = 1'b0;
          crc_d      = CRC_INIT;
          len_d      = 11'd0;
          hold_vld_d = 1'b0;
          first_d    = 1'b1;
        end else begin
          state_d = ST_DROP;
        end
      end
      ST_DATA: begin
        if (!rx_ctrl) begin
          state_d = ST_IDLE;
          // The last byte must not follow a data byte back to back, so it may slip one cycle.
          if (!hold_vld_q) begin
            bad_inc_s = 1'b1;
          end else if (out_valid_q) begin
            eof_pend_d = 1'b1;
          end else begin
            eof_now_s = 1'b1;
          end
        end else if (!phase_q) begin
          low_d   = rxd;
          phase_d = 1'b1;
        end else begin
          phase_d    = 1'b0;
          crc_d      = crc_byte_s;
          hold_d     = byte_s;
          hold_vld_d = 1'b1;
          if (len_q == MAX_LEN) begin
            len_d       = MAX_LEN_P1;
            state_d     = ST_DROP;
            out_valid_d = 1'b1;
            out_data_d  = hold_q;
            out_sof_d   = first_q;
            out_eof_d   = 1'b1;
            out_err_d   = 1'b1;
            out_len_d   = MAX_LEN;
            first_d     = 1'b0;
            bad_inc_s   = 1'b1;
          end else begin
            len_d = len_q + 11'd1;
            if (hold_vld_q) begin
              out_valid_d = 1'b1;
              out_data_d  = hold_q;
              out_sof_d   = first_q;
              first_d     = 1'b0;
            end else begin
              first_d = first_q;
            end
          end
        end
      end
      ST_DROP: begin
        if (!rx_ctrl) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (eof_now_s || eof_pend_q) begin
      out_valid_d = 1'b1;
      out_data_d  = hold_q;
      out_sof_d   = first_q;
      out_eof_d   = 1'b1;
      out_err_d   = frame_err_s;
      out_len_d   = len_q;
      good_inc_s  = ~frame_err_s;
      bad_inc_s   = frame_err_s;
    end else begin
      good_inc_s = 1'b0;
    end
  end

  // Saturating frame counters.
  always_comb begin
    if (good_inc_s && (good_cnt_q != 16'hFFFF)) begin
      good_cnt_d = good_cnt_q + 16'd1;
    end else begin
      good_cnt_d = good_cnt_q;
    end
    if (bad_inc_s && (bad_cnt_q != 16'hFFFF)) begin
      bad_cnt_d = bad_cnt_q + 16'd1;
    end else begin
      bad_cnt_d = bad_cnt_q;
    end
  end

  // State registers; a line already active at reset is treated as mid-frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      prev_ctrl_q <= 1'b1;
      phase_q     <= 1'b0;
      low_q       <= 4'h0;
      hold_q      <= 8'h00;
      hold_vld_q  <= 1'b0;
      first_q     <= 1'b0;
      crc_q       <= CRC_INIT;
      len_q       <= 11'd0;
      eof_pend_q  <= 1'b0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      out_err_q   <= 1'b0;
      out_len_q   <= 11'd0;
      good_cnt_q  <= 16'd0;
      bad_cnt_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      prev_ctrl_q <= prev_ctrl_d;
      phase_q     <= phase_d;
      low_q       <= low_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      first_q     <= first_d;
      crc_q       <= crc_d;
      len_q       <= len_d;
      eof_pend_q  <= eof_pend_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_eof_q   <= out_eof_d;
      out_err_q   <= out_err_d;
      out_len_q   <= out_len_d;
      good_cnt_q  <= good_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign out_eof   = out_eof_q;
  assign out_err   = out_err_q;
  assign out_len   = out_len_q;
  assign good_cnt  = good_cnt_q;
  assign bad_cnt   = bad_cnt_q;

endmodule

// File: tb/tb_rgmii_rx_deframer.sv
// Randomized scoreboard bench for rgmii_rx_deframer: a frame-level model pushes
// expected bytes, a negedge monitor pops and compares every presented byte.
module tb_rgmii_rx_deframer;

  localparam int MIN_FRAME = 64;
  localparam int MAX_FRAME = 1518;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_ctrl;
  logic [3:0]  rxd;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_sof;
  logic        out_eof;
  logic        out_err;
  logic [10:0] out_len;
  logic [15:0] good_cnt;
  logic [15:0] bad_cnt;

  rgmii_rx_deframer #(.MIN_FRAME(MIN_FRAME), .MAX_FRAME(MAX_FRAME)) dut (
    .clk(clk), .rst(rst), .rx_ctrl(rx_ctrl), .rxd(rxd),
    .out_data(out_data), .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof),
    .out_err(out_err), .out_len(out_len), .good_cnt(good_cnt), .bad_cnt(bad_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic        sof;
    logic        eof;
    logic        err;
    logic [10:0] len;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         failures = 0;
  int         exp_good = 0;
  int         exp_bad = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] bq[$];
  logic [3:0] nq[$];
  logic [7:0] cb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: every presented byte must match the head of the expected queue.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      check("back_to_back_valid", 32'(prev_valid), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_byte", 32'(out_valid), 32'd0);
      end else begin
        check("data", 32'(out_data), 32'(exp_q[0].data));
        check("sof", 32'(out_sof), 32'(exp_q[0].sof));
        check("eof", 32'(out_eof), 32'(exp_q[0].eof));
        if (exp_q[0].eof) begin
          check("err", 32'(out_err), 32'(exp_q[0].err));
          check("len", 32'(out_len), 32'(exp_q[0].len));
        end
        exp_q.delete(0);
      end
    end
    prev_valid <= out_valid;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // Standard Ethernet CRC over the first n bytes of cb (bit-serial form).
  function automatic logic [31:0] crc_of(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 8; k++) begin
        if (c[0] ^ cb[i][k]) c = {1'b0, c[31:1]} ^ 32'hEDB88320;
        else c = {1'b0, c[31:1]};
      end
    end
    return c;
  endfunction

  task automatic make_frame(input int plen);
    logic [31:0] f;
    bq.delete();
    for (int i = 0; i < plen; i++) bq.push_back(8'($urandom_range(0, 255)));
    cb = bq;
    f = ~crc_of(plen);
    for (int i = 0; i < 4; i++) bq.push_back(f[8*i +: 8]);
  endtask

  task automatic to_nibs();
    nq.delete();
    foreach (bq[i]) begin
      nq.push_back(bq[i][3:0]);
      nq.push_back(bq[i][7:4]);
    end
  endtask

  // Frame-level reference: what the receiver must deliver for the data nibbles in nq.
  task automatic model_frame();
    logic [7:0]  mb[$];
    int          nb;
    int          last;
    logic        err;
    logic [31:0] fcs;
    nb = nq.size() / 2;
    for (int i = 0; i < nb; i++) mb.push_back({nq[2*i+1], nq[2*i]});
    if (nb == 0) begin
      exp_bad++;
    end else begin
      err = (nb > MAX_FRAME) || (nb < MIN_FRAME) || ((nq.size() % 2) == 1);
      if (!err) begin
        cb = mb;
        fcs = ~crc_of(nb - 4);
        err = (fcs != {mb[nb-1], mb[nb-2], mb[nb-3], mb[nb-4]});
      end
      last = (nb > MAX_FRAME) ? MAX_FRAME : nb;
      for (int i = 0; i < last; i++)
        exp_q.push_back('{data: mb[i], sof: (i == 0), eof: (i == last - 1), err: err, len: 11'(last)});
      if (err) exp_bad++;
      else exp_good++;
    end
  endtask

  task automatic nib(input logic c, input logic [3:0] n);
    @(negedge clk);
    rx_ctrl = c;
    rxd     = n;
  endtask

  task automatic settle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      nib(1'b0, 4'h0);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (3) nib(1'b0, 4'h0);
    check("good_cnt", 32'(good_cnt), 32'(exp_good));
    check("bad_cnt", 32'(bad_cnt), 32'(exp_bad));
  endtask

  task automatic send_frame(input int pre_len);
    model_frame();
    for (int i = 0; i < pre_len; i++) nib(1'b1, 4'h5);
    nib(1'b1, 4'hD);
    foreach (nq[i]) nib(1'b1, nq[i]);
    nib(1'b0, 4'($urandom_range(0, 15)));
    settle();
  endtask

  initial begin
    rst = 1'b1;
    rx_ctrl = 1'b0;
    rxd = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_sof", 32'(out_sof), 32'd0);
    check("rst_eof", 32'(out_eof), 32'd0);
    check("rst_err", 32'(out_err), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_len", 32'(out_len), 32'd0);
    check("rst_good", 32'(good_cnt), 32'd0);
    check("rst_bad", 32'(bad_cnt), 32'd0);
    rst = 1'b0;
    repeat (3) nib(1'b0, 4'h0);

    // good 64-byte frame, then a single flipped bit, then a dribble nibble
    make_frame(60); to_nibs(); send_frame(7);
    make_frame(60); bq[19][0] = ~bq[19][0]; to_nibs(); send_frame(7);
    make_frame(60); to_nibs(); nq.push_back(4'($urandom_range(0, 15))); send_frame(7);

    // broken preamble held for 100 nibbles, then a good frame
    nib(1'b1, 4'h5); nib(1'b1, 4'h5); nib(1'b1, 4'h3);
    repeat (97) nib(1'b1, 4'($urandom_range(0, 15)));
    nib(1'b0, 4'h0);
    settle();
    make_frame(60); to_nibs(); send_frame(7);

    // carrier drops inside the preamble
    nib(1'b1, 4'h5); nib(1'b1, 4'h5); nib(1'b1, 4'h5); nib(1'b0, 4'h0);
    settle();

    // 40-byte runt with valid FCS, then a 1600-byte stream
    make_frame(36); to_nibs(); send_frame(7);
    make_frame(1596); to_nibs(); send_frame(7);

    // reset for one clock at byte 20 with rx_ctrl still high
    make_frame(60); to_nibs();
    for (int i = 0; i < 19; i++)
      exp_q.push_back('{data: bq[i], sof: (i == 0), eof: 1'b0, err: 1'b0, len: 11'd0});
    repeat (7) nib(1'b1, 4'h5);
    nib(1'b1, 4'hD);
    for (int i = 0; i < 40; i++) nib(1'b1, nq[i]);
    @(negedge clk); rst = 1'b1; rxd = nq[40];
    @(negedge clk); rst = 1'b0; rxd = nq[41];
    exp_good = 0;
    exp_bad = 0;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_eof", 32'(out_eof), 32'd0);
    check("midrst_good", 32'(good_cnt), 32'd0);
    check("midrst_bad", 32'(bad_cnt), 32'd0);
    for (int i = 42; i < nq.size(); i++) nib(1'b1, nq[i]);
    nib(1'b0, 4'h0);
    settle();
    make_frame(60); to_nibs(); send_frame(7);

    // randomized mix of frame kinds
    for (int t = 0; t < 12; t++) begin
      int kind;
      int idx;
      kind = $urandom_range(0, 5);
      case (kind)
        0: begin make_frame($urandom_range(60, 120)); to_nibs(); end
        1: begin
          make_frame($urandom_range(60, 120));
          idx = $urandom_range(0, bq.size() - 1);
          bq[idx] = bq[idx] ^ (8'h01 << $urandom_range(0, 7));
          to_nibs();
        end
        2: begin make_frame($urandom_range(60, 90)); to_nibs(); nq.push_back(4'($urandom_range(0, 15))); end
        3: begin make_frame($urandom_range(1, 50)); to_nibs(); end
        4: begin bq.delete(); bq.push_back(8'($urandom_range(0, 255))); to_nibs(); end
        default: begin
          nq.delete();
          if ($urandom_range(0, 1) == 1) nq.push_back(4'($urandom_range(0, 15)));
        end
      endcase
      send_frame($urandom_range(1, 15));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
